// File: rtl/nonce_report_queue.sv
// Golden-nonce queue feeding the JTAG probe word; host pops the head by toggling ack_toggle.
// Optional macro NONCE_QUEUE_TIMESTAMP_EN adds a per-entry cycle timestamp and head_timestamp port.
module nonce_report_queue #(
    parameter int DEPTH       = 16,
    parameter int NONCE_WIDTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     nonce_valid,
    input  logic [NONCE_WIDTH-1:0]   nonce_in,
    input  logic                     ack_toggle,
    output logic                     head_valid,
    output logic [NONCE_WIDTH-1:0]   head_nonce,
`ifdef NONCE_QUEUE_TIMESTAMP_EN
    output logic [31:0]              head_timestamp,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               pop_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [2:0]    ARM_CYCLES = 3'(SYNC_STAGES + 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [2:0]             arm_q, arm_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [7:0]             pop_count_q, pop_count_d;
    logic                   overflow_q, overflow_d;
    logic                   head_valid_q, head_valid_d;
    logic [NONCE_WIDTH-1:0] head_nonce_q, head_nonce_d;
    logic [NONCE_WIDTH-1:0] mem_q [DEPTH];
    logic                   ack_pulse_s, pop_s, push_s, full_s, empty_s, bypass_s;
`ifdef NONCE_QUEUE_TIMESTAMP_EN
    logic [31:0]            ts_cnt_q, ts_cnt_d;
    logic [31:0]            head_ts_q, head_ts_d;
    logic [31:0]            ts_mem_q [DEPTH];
`endif

    // Next-state logic: ack edge detection with arming window, queue bookkeeping, head lookahead.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ack_toggle};
        edge_d = sync_q[SYNC_STAGES-1];
        if (arm_q == ARM_CYCLES) begin
            arm_d       = arm_q;
            ack_pulse_s = sync_q[SYNC_STAGES-1] ^ edge_q;
        end else begin
            arm_d       = arm_q + 3'd1;
            ack_pulse_s = 1'b0;
        end

        full_s     = (level_q == LEVEL_FULL);
        empty_s    = (level_q == '0);
        pop_s      = ack_pulse_s & ~empty_s;
        push_s     = nonce_valid & (~full_s | pop_s);
        overflow_d = overflow_q | (nonce_valid & full_s & ~pop_s);

        wr_ptr_d    = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        pop_count_d = pop_s  ? (pop_count_q + 8'd1) : pop_count_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        // A push landing on the next head slot is not in memory yet, so forward it.
        bypass_s = push_s & (wr_ptr_q == rd_ptr_d);
        if (level_d != '0) begin
            head_valid_d = 1'b1;
            head_nonce_d = bypass_s ? nonce_in : mem_q[rd_ptr_d];
        end else begin
            head_valid_d = 1'b0;
            head_nonce_d = '0;
        end
`ifdef NONCE_QUEUE_TIMESTAMP_EN
        ts_cnt_d = ts_cnt_q + 32'd1;
        if (level_d != '0) begin
            head_ts_d = bypass_s ? ts_cnt_q : ts_mem_q[rd_ptr_d];
        end else begin
            head_ts_d = 32'd0;
        end
`endif
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            edge_q       <= 1'b0;
            arm_q        <= 3'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            pop_count_q  <= 8'd0;
            overflow_q   <= 1'b0;
            head_valid_q <= 1'b0;
            head_nonce_q <= '0;
`ifdef NONCE_QUEUE_TIMESTAMP_EN
            ts_cnt_q     <= 32'd0;
            head_ts_q    <= 32'd0;
`endif
        end else begin
            sync_q       <= sync_d;
            edge_q       <= edge_d;
            arm_q        <= arm_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            pop_count_q  <= pop_count_d;
            overflow_q   <= overflow_d;
            head_valid_q <= head_valid_d;
            head_nonce_q <= head_nonce_d;
`ifdef NONCE_QUEUE_TIMESTAMP_EN
            ts_cnt_q     <= ts_cnt_d;
            head_ts_q    <= head_ts_d;
`endif
        end
    end

    // Entry storage; contents survive reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= nonce_in;
`ifdef NONCE_QUEUE_TIMESTAMP_EN
            ts_mem_q[wr_ptr_q] <= ts_cnt_q;
`endif
        end
    end

    assign head_valid = head_valid_q;
    assign head_nonce = head_nonce_q;
    assign level      = level_q;
    assign pop_count  = pop_count_q;
    assign overflow   = overflow_q;
`ifdef NONCE_QUEUE_TIMESTAMP_EN
    assign head_timestamp = head_ts_q;
`endif

endmodule

// File: tb/tb_nonce_report_queue.sv
// Directed self-checking bench for nonce_report_queue (default parameters).
module tb_nonce_report_queue;

    localparam int DEPTH = 16;
    localparam int NW    = 32;
    localparam int SS    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          nonce_valid;
    logic [NW-1:0] nonce_in;
    logic          ack_toggle;
    logic          head_valid;
    logic [NW-1:0] head_nonce;
    logic [4:0]    level;
    logic [7:0]    pop_count;
    logic          overflow;
`ifdef NONCE_QUEUE_TIMESTAMP_EN
    logic [31:0]   head_timestamp;
`endif

    int checks = 0;
    int errors = 0;

    nonce_report_queue #(.DEPTH(DEPTH), .NONCE_WIDTH(NW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .nonce_valid(nonce_valid), .nonce_in(nonce_in),
        .ack_toggle(ack_toggle), .head_valid(head_valid), .head_nonce(head_nonce),
`ifdef NONCE_QUEUE_TIMESTAMP_EN
        .head_timestamp(head_timestamp),
`endif
        .level(level), .pop_count(pop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        nonce_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
    endtask

    task automatic push(input logic [NW-1:0] v);
        nonce_valid = 1'b1;
        nonce_in = v;
        tick();
        nonce_valid = 1'b0;
    endtask

    task automatic ack;
        ack_toggle = ~ack_toggle;
        repeat (SS + 1) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1; ack_toggle = 1'b1; nonce_valid = 1'b0; nonce_in = 32'h0;
        repeat (3) tick();
        checks++; if (head_valid !== 1'b0) begin errors++; $display("FAIL reset_head_valid got %0h want 0", head_valid); end
        checks++; if (head_nonce !== 32'h0) begin errors++; $display("FAIL reset_head_nonce got %0h want 0", head_nonce); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (pop_count !== 8'd0) begin errors++; $display("FAIL reset_pop_count got %0d want 0", pop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0h want 0", overflow); end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (pop_count !== 8'd0) begin errors++; $display("FAIL arm_pop_count cycle %0d got %0d want 0", i, pop_count); end
        end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL arm_level got %0d want 0", level); end
        checks++; if (head_valid !== 1'b0) begin errors++; $display("FAIL arm_head_valid got %0h want 0", head_valid); end
    endtask

    task automatic test_basic;
        push(32'hDEADBEEF);
        checks++; if (head_nonce !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_first_head got %h want deadbeef", head_nonce); end
        checks++; if (head_valid !== 1'b1) begin errors++; $display("FAIL basic_head_valid got %0h want 1", head_valid); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL basic_level1 got %0d want 1", level); end
        push(32'h00000001);
        checks++; if (level !== 5'd2) begin errors++; $display("FAIL basic_level2 got %0d want 2", level); end
        checks++; if (head_nonce !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_head_kept got %h want deadbeef", head_nonce); end
        ack_toggle = ~ack_toggle;
        tick(); tick();
        checks++; if (level !== 5'd2) begin errors++; $display("FAIL basic_early_pop level got %0d want 2", level); end
        tick();
        checks++; if (head_nonce !== 32'h00000001) begin errors++; $display("FAIL basic_pop_head got %h want 00000001", head_nonce); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL basic_pop_level got %0d want 1", level); end
        checks++; if (pop_count !== 8'd1) begin errors++; $display("FAIL basic_pop_count got %0d want 1", pop_count); end
        ack();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL basic_empty_level got %0d want 0", level); end
        checks++; if (head_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_valid got %0h want 0", head_valid); end
        checks++; if (head_nonce !== 32'h0) begin errors++; $display("FAIL basic_empty_head got %h want 0", head_nonce); end
        checks++; if (pop_count !== 8'd2) begin errors++; $display("FAIL basic_pop_count2 got %0d want 2", pop_count); end
    endtask

    task automatic test_overflow;
        apply_reset();
        checks++; if (pop_count !== 8'd0) begin errors++; $display("FAIL ovf_reset_pop_count got %0d want 0", pop_count); end
        for (int i = 1; i <= DEPTH + 1; i++) push(32'(i));
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h want 1", overflow); end
        checks++; if (head_nonce !== 32'd1) begin errors++; $display("FAIL ovf_head got %0d want 1", head_nonce); end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (head_nonce !== 32'(i)) begin errors++; $display("FAIL ovf_order got %0d want %0d", head_nonce, i); end
            ack();
        end
        checks++; if (head_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_valid got %0h want 0", head_valid); end
        checks++; if (head_nonce !== 32'h0) begin errors++; $display("FAIL ovf_drain_head got %0d want 0", head_nonce); end
        checks++; if (pop_count !== 8'd16) begin errors++; $display("FAIL ovf_pop_count got %0d want 16", pop_count); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf_drain_level got %0d want 0", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0h want 1", overflow); end
    endtask

    task automatic test_full_simultaneous;
        apply_reset();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_reset_overflow got %0h want 0", overflow); end
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL simul_full_level got %0d want 16", level); end
        ack_toggle = ~ack_toggle;
        tick(); tick();
        nonce_valid = 1'b1; nonce_in = 32'hABC;
        tick();
        nonce_valid = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL simul_level got %0d want 16", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got %0h want 0", overflow); end
        checks++; if (pop_count !== 8'd1) begin errors++; $display("FAIL simul_pop_count got %0d want 1", pop_count); end
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (head_nonce !== 32'h100 + 32'(i)) begin errors++; $display("FAIL simul_order got %h want %h", head_nonce, 32'h100 + 32'(i)); end
            ack();
        end
        checks++; if (head_nonce !== 32'hABC) begin errors++; $display("FAIL simul_new_head got %h want abc", head_nonce); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL simul_last_level got %0d want 1", level); end
    endtask

    task automatic test_empty_ack;
        apply_reset();
        repeat (3) ack();
        tick();
        checks++; if (pop_count !== 8'd0) begin errors++; $display("FAIL empty_ack_pop_count got %0d want 0", pop_count); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL empty_ack_level got %0d want 0", level); end
        checks++; if (head_valid !== 1'b0) begin errors++; $display("FAIL empty_ack_valid got %0h want 0", head_valid); end
        push(32'h12345678);
        checks++; if (head_nonce !== 32'h12345678) begin errors++; $display("FAIL empty_push_head got %h want 12345678", head_nonce); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL empty_push_level got %0d want 1", level); end
        checks++; if (head_valid !== 1'b1) begin errors++; $display("FAIL empty_push_valid got %0h want 1", head_valid); end
    endtask

    task automatic test_reset_mid;
        push(32'hA);
        push(32'hB);
        reset = 1'b1;
        ack_toggle = ~ack_toggle;
        tick(); tick();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_level got %0d want 0", level); end
        checks++; if (head_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0h want 0", head_valid); end
        checks++; if (head_nonce !== 32'h0) begin errors++; $display("FAIL mid_head got %h want 0", head_nonce); end
        reset = 1'b0;
        push(32'hC);
        repeat (10) tick();
        checks++; if (pop_count !== 8'd0) begin errors++; $display("FAIL mid_rearm_pop_count got %0d want 0", pop_count); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL mid_rearm_level got %0d want 1", level); end
        checks++; if (head_nonce !== 32'hC) begin errors++; $display("FAIL mid_rearm_head got %h want c", head_nonce); end
    endtask

`ifdef NONCE_QUEUE_TIMESTAMP_EN
    task automatic test_timestamp;
        reset = 1'b1; nonce_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (head_timestamp !== 32'd0) begin errors++; $display("FAIL ts_reset got %0d want 0", head_timestamp); end
        repeat (100) tick();
        push(32'h55);
        checks++; if (head_timestamp !== 32'd100) begin errors++; $display("FAIL ts_value got %0d want 100", head_timestamp); end
        ack();
        checks++; if (head_timestamp !== 32'd0) begin errors++; $display("FAIL ts_empty got %0d want 0", head_timestamp); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_simultaneous();
        test_empty_ack();
        test_reset_mid();
`ifdef NONCE_QUEUE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_report_queue.md
Name: nonce_report_queue

Overview:
- Buffers golden nonces produced by the hashing cores and presents the oldest one to the host through a JTAG probe word.
- Sits directly upstream of the probe input of the JTAG source/probe wire.
- The host acknowledges each nonce it has read by toggling one bit of a JTAG source wire. The block synchronises that toggle and pops the head entry.
- Prevents nonces being lost when several are found between host polls.

Parameters:
- DEPTH, 16, number of queue entries; power of two, ≥2.
- NONCE_WIDTH, 32, width of one nonce.
- SYNC_STAGES, 2, flip-flop stages synchronising ack_toggle; ≥2.

Ports:
- clk  input  1  single clock for all logic (hash clock domain).
- reset  input  1  synchronous, active-high reset.
- nonce_valid  input  1  one-cycle strobe: nonce_in holds a found nonce.
- nonce_in  input  NONCE_WIDTH  found nonce.
- ack_toggle  input  1  host acknowledge from JTAG source wire; asynchronous to clk; each level change means "head consumed".
- head_valid  output  1  queue non-empty; head_nonce is meaningful.
- head_nonce  output  NONCE_WIDTH  oldest queued nonce; 0 when empty.
- level  output  clog2(DEPTH)+1  number of queued entries.
- pop_count  output  8  count of accepted pops, wraps 255→0; lets the host detect a stale probe read.
- overflow  output  1  sticky: at least one nonce was dropped.

Behaviour:
- Reset values: head_valid=0, head_nonce=0, level=0, pop_count=0, overflow=0. Read/write pointers=0. Synchroniser stages and edge register=0.
- Storage: circular buffer of DEPTH entries.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - Full when level==DEPTH; empty when level==0.
- Push: occurs on a cycle with nonce_valid=1 and not full, or with nonce_valid=1, full and a pop on the same cycle.
- Drop: nonce_valid=1, full and no pop. The nonce is discarded, overflow is set to 1, and state is otherwise unchanged. overflow clears only on reset.
- Ack synchroniser: ack_toggle passes through SYNC_STAGES flops, then one edge register.
  - ack_pulse = last sync stage XOR edge register.
  - Latency from an ack_toggle change to the pop is SYNC_STAGES+1 clk edges.
- Arming window: after reset deasserts, the edge register copies the synchronised value and ack_pulse is forced to 0 for SYNC_STAGES+1 cycles. An ack_toggle already high at reset release therefore causes no spurious pop. A 3-bit arm counter implements this.
- Pop: ack_pulse=1 and not empty.
  - Advance the read pointer and increment pop_count.
  - ack_pulse while empty is ignored: no pointer or pop_count change.
- Simultaneous push and pop: level is unchanged.
  - When level==1, the new nonce becomes head the next cycle.
  - When empty, only the push takes effect.
- Outputs are registered and updated on the same edge as the state change:
  - level reflects the new count one cycle after the event.
  - head_valid = (level!=0).
  - head_nonce = mem[rd_ptr] when non-empty, else 0.
  - A push into an empty queue raises head_valid and shows the nonce one cycle after the nonce_valid cycle.
- Reset mid-operation:
  - All entries are discarded and the arming window restarts.
  - Memory contents need not be cleared; only the pointers, level and outputs are reset.
- ack_toggle edges closer together than SYNC_STAGES+1 cycles are not guaranteed to be counted individually. The host polls far slower than this, so no extra handling is required.

Optional Feature:
- Macro: NONCE_QUEUE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter runs from 0 after reset and wraps.
  - Its value is stored alongside each pushed nonce.
  - An extra output port head_timestamp (32 bits) follows head_nonce: value of the head entry, 0 when empty, 0 at reset.
- Not defined: no counter, no timestamp storage, no head_timestamp port. All other behaviour is identical.

Test Plan:
- Reset release with ack_toggle held 1; then 20 idle cycles -> pop_count=0, level=0, head_valid=0; no spurious pop.
- Push 0xDEADBEEF, then 0x00000001 -> head_nonce=0xDEADBEEF one cycle after the first strobe, level=2. Toggle ack -> SYNC_STAGES+1 cycles later head_nonce=0x00000001, level=1, pop_count=1.
- Push DEPTH+1 distinct nonces (1..17) with no acks -> level=16, overflow=1, head_nonce=1. Acking 16 times returns 1..16 in order; nonce 17 never appears; pop_count=16; head_valid=0.
- Queue full; nonce_valid coincides with ack_pulse -> no drop, overflow stays 0, level stays 16, new nonce appears after the other 15.
- Empty queue; toggle ack 3 times -> pop_count=0, level=0. Then push 0x12345678 -> head_nonce=0x12345678.
- With NONCE_QUEUE_TIMESTAMP_EN: push at cycle 100 after reset -> head_timestamp=100 (±0 by spec: counter value sampled on the nonce_valid cycle).
